// File: rtl/ahbl_ram_arbiter_if.sv
// rtl/ahbl_ram_arbiter_if.sv - signal bundle between two AHB-Lite masters, the arbiter and one RAM slave
interface ahbl_ram_arbiter_if;
  // Master 0 port
  logic [31:0] M0_HADDR;
  logic [1:0]  M0_HTRANS;
  logic [2:0]  M0_HSIZE;
  logic        M0_HWRITE;
  logic [31:0] M0_HWDATA;
  logic        M0_HREADY;
  logic [31:0] M0_HRDATA;

  // Master 1 port
  logic [31:0] M1_HADDR;
  logic [1:0]  M1_HTRANS;
  logic [2:0]  M1_HSIZE;
  logic        M1_HWRITE;
  logic [31:0] M1_HWDATA;
  logic        M1_HREADY;
  logic [31:0] M1_HRDATA;

  // RAM slave port
  logic [31:0] S_HADDR;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;
  logic        S_HWRITE;
  logic        S_HSEL;
  logic        S_HREADY;
  logic [31:0] S_HWDATA;
  logic        S_HREADYOUT;
  logic [31:0] S_HRDATA;

  // Arbiter view: serves both masters, drives the RAM
  modport slave (
    input  M0_HADDR, M0_HTRANS, M0_HSIZE, M0_HWRITE, M0_HWDATA,
    output M0_HREADY, M0_HRDATA,
    input  M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA,
    output M1_HREADY, M1_HRDATA,
    output S_HADDR, S_HTRANS, S_HSIZE, S_HWRITE, S_HSEL, S_HREADY, S_HWDATA,
    input  S_HREADYOUT, S_HRDATA
  );

  // Environment view: the two masters and the RAM around the arbiter
  modport master (
    output M0_HADDR, M0_HTRANS, M0_HSIZE, M0_HWRITE, M0_HWDATA,
    input  M0_HREADY, M0_HRDATA,
    output M1_HADDR, M1_HTRANS, M1_HSIZE, M1_HWRITE, M1_HWDATA,
    input  M1_HREADY, M1_HRDATA,
    input  S_HADDR, S_HTRANS, S_HSIZE, S_HWRITE, S_HSEL, S_HREADY, S_HWDATA,
    output S_HREADYOUT, S_HRDATA
  );
endinterface

// File: rtl/ahbl_ram_arbiter.sv
// rtl/ahbl_ram_arbiter.sv - two-master AHB-Lite arbiter in front of a single RAM slave (AHBL_ARB_ROUND_ROBIN_EN selects round-robin conflict policy)
module ahbl_ram_arbiter #(
  parameter int MAX_GRANT = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahbl_ram_arbiter_if.slave    bus
);

  localparam int CW = $clog2(MAX_GRANT + 1);

  // Address-phase attributes of one transfer, as captured into a pend buffer
  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
  } addr_t;

  // Buffered (accepted but not yet issued) request per master
  logic [1:0]       r_pend;
  addr_t [1:0]      r_pend_req;

  // Owner of the RAM data phase currently in progress
  logic             r_dp_valid;
  logic             r_dp_owner;

  // Consecutive-grant tracking for the starvation cap
  logic [CW-1:0]    r_gcnt;
  logic             r_glast;

`ifdef AHBL_ARB_ROUND_ROBIN_EN
  logic             r_rr_ptr;
`endif

  addr_t [1:0]      w_live;
  logic  [1:0]      w_mready;
  logic  [1:0]      w_live_req;
  logic  [1:0]      w_req;
  logic  [1:0]      w_grant;
  logic             w_pref;
  logic             w_capped;
  logic             w_conflict;
  logic             w_issue;
  logic             w_winner;
  logic             w_from_pend;
  addr_t            w_sel;

  assign w_live[0] = {bus.M0_HADDR, bus.M0_HTRANS, bus.M0_HSIZE, bus.M0_HWRITE};
  assign w_live[1] = {bus.M1_HADDR, bus.M1_HTRANS, bus.M1_HSIZE, bus.M1_HWRITE};

  // Master HREADY: the data-phase owner follows the RAM; a master with a buffered request is stalled
  always_comb begin
    w_mready = 2'b11;
    if (r_dp_valid && !r_dp_owner) begin
      w_mready[0] = bus.S_HREADYOUT;
    end else if (r_pend[0]) begin
      w_mready[0] = 1'b0;
    end
    if (r_dp_valid && r_dp_owner) begin
      w_mready[1] = bus.S_HREADYOUT;
    end else if (r_pend[1]) begin
      w_mready[1] = 1'b0;
    end
  end

  // A live request is an address phase the master sees accepted (its HREADY high)
  assign w_live_req = w_mready & {bus.M1_HTRANS[1], bus.M0_HTRANS[1]} & ~r_pend;
  assign w_req      = r_pend | w_live_req;
  assign w_conflict = &w_req;

`ifdef AHBL_ARB_ROUND_ROBIN_EN
  assign w_pref = r_rr_ptr;
`else
  assign w_pref = 1'b0;
`endif

  // The preferred master yields once it has used up its consecutive-grant allowance
  assign w_capped = (r_gcnt == CW'(MAX_GRANT)) && (r_glast == w_pref);

  // Pick at most one winner; the RAM only takes an address phase while it is ready
  always_comb begin
    w_winner = w_req[1] & ~w_req[0];
    if (w_conflict) begin
      w_winner = w_pref ^ w_capped;
    end
    w_issue     = bus.S_HREADYOUT & ~HRESET & (|w_req);
    w_grant     = 2'b00;
    if (w_issue) begin
      w_grant = w_winner ? 2'b10 : 2'b01;
    end
    w_from_pend = r_pend[w_winner];
    w_sel       = w_from_pend ? r_pend_req[w_winner] : w_live[w_winner];
  end

  // RAM address phase from the winner; IDLE and deselected otherwise
  always_comb begin
    bus.S_HADDR  = '0;
    bus.S_HTRANS = 2'b00;
    bus.S_HSIZE  = 3'b000;
    bus.S_HWRITE = 1'b0;
    bus.S_HSEL   = 1'b0;
    if (w_issue) begin
      bus.S_HADDR  = w_sel.haddr;
      bus.S_HTRANS = w_sel.htrans;
      bus.S_HSIZE  = w_sel.hsize;
      bus.S_HWRITE = w_sel.hwrite;
      bus.S_HSEL   = 1'b1;
    end
  end

  assign bus.S_HREADY  = bus.S_HREADYOUT;
  assign bus.S_HWDATA  = r_dp_owner ? bus.M1_HWDATA : bus.M0_HWDATA;
  assign bus.M0_HRDATA = bus.S_HRDATA;
  assign bus.M1_HRDATA = bus.S_HRDATA;
  assign bus.M0_HREADY = w_mready[0];
  assign bus.M1_HREADY = w_mready[1];

  // Pend buffers: capture accepted-but-not-issued live requests, release when the buffer is issued
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pend     <= 2'b00;
      r_pend_req <= '0;
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (w_grant[x] && r_pend[x]) begin
          r_pend[x] <= 1'b0;
        end else if (w_live_req[x] && !w_grant[x]) begin
          r_pend[x]     <= 1'b1;
          r_pend_req[x] <= w_live[x];
        end
      end
    end
  end

  // Data-phase ownership advances only when the RAM completes the current phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_owner <= 1'b0;
    end else if (bus.S_HREADYOUT) begin
      r_dp_valid <= w_issue;
      if (w_issue) begin
        r_dp_owner <= w_winner;
      end
    end
  end

  // Consecutive-grant counter: saturates, restarts at 1 on owner change, clears on an idle cycle
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_gcnt  <= '0;
      r_glast <= 1'b0;
    end else if (bus.S_HREADYOUT) begin
      if (!w_issue) begin
        r_gcnt <= '0;
      end else if ((w_winner == r_glast) && (r_gcnt != '0)) begin
        if (r_gcnt != CW'(MAX_GRANT)) begin
          r_gcnt <= r_gcnt + CW'(1);
        end
      end else begin
        r_gcnt  <= CW'(1);
        r_glast <= w_winner;
      end
    end
  end

`ifdef AHBL_ARB_ROUND_ROBIN_EN
  // Round-robin pointer hands preference to the loser after every contested grant
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rr_ptr <= 1'b0;
    end else if (w_issue && w_conflict) begin
      r_rr_ptr <= ~w_winner;
    end
  end
`endif

endmodule

// File: tb/tb_ahbl_ram_arbiter.sv
// tb/tb_ahbl_ram_arbiter.sv - scoreboard bench for ahbl_ram_arbiter with two master models and a RAM model
module tb_ahbl_ram_arbiter;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahbl_ram_arbiter_if bus();

  ahbl_ram_arbiter #(.MAX_GRANT(4)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } cmd_t;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_t        q0[$];
  cmd_t        q1[$];
  logic [31:0] e0[$];
  logic [31:0] e1[$];
  cmd_t        ap[2];
  cmd_t        dp[2];
  logic        ap_v[2];
  logic        dp_v[2];

  logic [31:0] mem [0:255];
  logic [31:0] ram_dp_addr = '0;
  logic        ram_dp_v    = 1'b0;
  logic        ram_dp_wr   = 1'b0;
  logic        ram_ready   = 1'b1;
  int          ram_wait    = 0;

  int          wr_count = 0;
  int          cyc      = 0;
  int          low0     = 0;
  int          low1     = 0;
  logic [31:0] glog[$];
  int          gcyc[$];

  assign bus.S_HREADYOUT = ram_ready;
  assign bus.S_HRDATA    = mem[ram_dp_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] glog_at(input int i);
    if (i < glog.size()) return glog[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic push_wr(input int m, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.addr = a; c.wr = 1'b1; c.data = d;
    if (m == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  task automatic push_rd(input int m, input logic [31:0] a, input logic [31:0] exp);
    cmd_t c;
    c.addr = a; c.wr = 1'b0; c.data = '0;
    if (m == 0) begin q0.push_back(c); e0.push_back(exp); end
    else begin q1.push_back(c); e1.push_back(exp); end
  endtask

  task automatic drive_masters();
    bus.M0_HADDR  = ap_v[0] ? ap[0].addr : 32'h0;
    bus.M0_HTRANS = ap_v[0] ? 2'b10 : 2'b00;
    bus.M0_HSIZE  = 3'b010;
    bus.M0_HWRITE = ap_v[0] & ap[0].wr;
    bus.M0_HWDATA = dp_v[0] ? dp[0].data : 32'h0;
    bus.M1_HADDR  = ap_v[1] ? ap[1].addr : 32'h0;
    bus.M1_HTRANS = ap_v[1] ? 2'b10 : 2'b00;
    bus.M1_HSIZE  = 3'b010;
    bus.M1_HWRITE = ap_v[1] & ap[1].wr;
    bus.M1_HWDATA = dp_v[1] ? dp[1].data : 32'h0;
  endtask

  task automatic tick();
    logic [1:0]  r;
    logic [31:0] rd0, rd1, s_addr, s_wd;
    logic        s_iss, s_rdy, s_wr, rst_s;
    @(negedge HCLK);
    r      = {bus.M1_HREADY, bus.M0_HREADY};
    rd0    = bus.M0_HRDATA;
    rd1    = bus.M1_HRDATA;
    s_rdy  = bus.S_HREADYOUT;
    s_iss  = bus.S_HSEL & bus.S_HTRANS[1] & bus.S_HREADY;
    s_addr = bus.S_HADDR;
    s_wr   = bus.S_HWRITE;
    s_wd   = bus.S_HWDATA;
    rst_s  = HRESET;
    if (s_iss) begin glog.push_back(s_addr); gcyc.push_back(cyc); end
    if (!r[0]) low0++;
    if (!r[1]) low1++;
    @(posedge HCLK);
    #1;
    cyc++;
    if (rst_s) begin
      ram_dp_v = 1'b0;
      for (int m = 0; m < 2; m++) begin ap_v[m] = 1'b0; dp_v[m] = 1'b0; end
    end else begin
      if (s_rdy) begin
        if (ram_dp_v && ram_dp_wr) begin
          mem[ram_dp_addr[9:2]] = s_wd;
          wr_count++;
        end
        ram_dp_v    = s_iss;
        ram_dp_addr = s_addr;
        ram_dp_wr   = s_wr;
      end
      for (int m = 0; m < 2; m++) begin
        if (r[m]) begin
          if (dp_v[m] && !dp[m].wr) begin
            if (m == 0) begin
              if (e0.size() == 0) check("m0_unexpected_read", 32'd1, 32'd0);
              else check("m0_rdata", rd0, e0.pop_front());
            end else begin
              if (e1.size() == 0) check("m1_unexpected_read", 32'd1, 32'd0);
              else check("m1_rdata", rd1, e1.pop_front());
            end
          end
          dp[m]   = ap[m];
          dp_v[m] = ap_v[m];
          ap_v[m] = 1'b0;
          if (m == 0 && q0.size() > 0) begin ap[0] = q0.pop_front(); ap_v[0] = 1'b1; end
          if (m == 1 && q1.size() > 0) begin ap[1] = q1.pop_front(); ap_v[1] = 1'b1; end
        end
      end
    end
    if (ram_wait > 0) begin ram_ready = 1'b0; ram_wait--; end
    else ram_ready = 1'b1;
    drive_masters();
  endtask

  function automatic logic bfm_idle();
    return (q0.size() == 0) && (q1.size() == 0) && !ap_v[0] && !ap_v[1] && !dp_v[0] && !dp_v[1];
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!bfm_idle() && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_in_time"}, 32'(n < 300), 32'd1);
    check({tag, "_reads_left"}, 32'(e0.size() + e1.size()), 32'd0);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    for (int m = 0; m < 2; m++) begin ap_v[m] = 1'b0; dp_v[m] = 1'b0; end
    ram_dp_v  = 1'b0;
    ram_wait  = 0;
    ram_ready = 1'b1;
    drive_masters();
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int m = 0; m < 2; m++) begin ap_v[m] = 1'b0; dp_v[m] = 1'b0; end
    drive_masters();
    #2;
    check("rst_m0_hready", 32'(bus.M0_HREADY), 32'd1);
    check("rst_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("rst_s_htrans",  32'(bus.S_HTRANS),  32'd0);
    check("rst_s_hsel",    32'(bus.S_HSEL),    32'd0);
    do_reset();

    // Uncontended write then read from M0
    low0 = 0;
    push_wr(0, 32'h100, 32'hDEAD_BEEF);
    push_rd(0, 32'h100, 32'hDEAD_BEEF);
    wait_idle("unc");
    check("unc_m0_hready_low_cycles", 32'(low0), 32'd0);
    check("unc_mem_0x100", mem[32'h100 >> 2], 32'hDEAD_BEEF);

`ifndef AHBL_ARB_ROUND_ROBIN_EN
    // Same-cycle collision, fixed M0 priority
    glog.delete(); low0 = 0; low1 = 0;
    push_wr(0, 32'h10, 32'h1111_1111);
    push_wr(1, 32'h14, 32'h2222_2222);
    wait_idle("col");
    check("col_grants",       32'(glog.size()), 32'd2);
    check("col_first_grant",  glog_at(0), 32'h10);
    check("col_second_grant", glog_at(1), 32'h14);
    check("col_m1_low",       32'(low1), 32'd1);
    check("col_m0_low",       32'(low0), 32'd0);
    check("col_mem_0x10",     mem[32'h10 >> 2], 32'h1111_1111);
    check("col_mem_0x14",     mem[32'h14 >> 2], 32'h2222_2222);
    push_rd(1, 32'h10, 32'h1111_1111);
    push_rd(1, 32'h14, 32'h2222_2222);
    wait_idle("col_rb");

    // Starvation cap: M0 streams 10 reads, M1 one read
    for (int i = 0; i < 10; i++) mem[(32'h200 >> 2) + i] = 32'h1000 + 32'(i);
    mem[32'h300 >> 2] = 32'hCAFE_0001;
    glog.delete(); low0 = 0;
    for (int i = 0; i < 10; i++) push_rd(0, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
    push_rd(1, 32'h300, 32'hCAFE_0001);
    wait_idle("cap");
    check("cap_grants",  32'(glog.size()), 32'd11);
    check("cap_grant3",  glog_at(3), 32'h20C);
    check("cap_grant4",  glog_at(4), 32'h300);
    check("cap_grant5",  glog_at(5), 32'h210);
    check("cap_grant10", glog_at(10), 32'h224);
    check("cap_m0_low",  32'(low0), 32'd1);
`else
    // Round-robin: both masters stream 6 reads
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem[(32'h200 >> 2) + i] = 32'h1000 + 32'(i);
      mem[(32'h300 >> 2) + i] = 32'h2000 + 32'(i);
    end
    glog.delete();
    for (int i = 0; i < 6; i++) begin
      push_rd(0, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
      push_rd(1, 32'h300 + 32'(4 * i), 32'h2000 + 32'(i));
    end
    wait_idle("rr");
    check("rr_grants", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      a = ((i % 2) == 0) ? 32'h200 : 32'h300;
      check("rr_grant_addr", glog_at(i), a + 32'(4 * (i / 2)));
    end
`endif

    // Slave wait states during M1 data phase while M0 requests
    mem[32'h300 >> 2] = 32'hCAFE_0001;
    mem[32'h204 >> 2] = 32'h0000_1001;
    glog.delete(); gcyc.delete();
    push_rd(1, 32'h300, 32'hCAFE_0001);
    tick();
    ram_wait = 3;
    push_rd(0, 32'h204, 32'h0000_1001);
    wait_idle("wait");
    check("wait_grants", 32'(glog.size()), 32'd2);
    check("wait_first",  glog_at(0), 32'h300);
    check("wait_second", glog_at(1), 32'h204);
    if (gcyc.size() == 2) check("wait_issue_gap", 32'(gcyc[1] - gcyc[0]), 32'd4);
    else check("wait_issue_count", 32'(gcyc.size()), 32'd2);

    // Reset asserted during an M1 write data phase, with M0 presenting a request
    wr0 = wr_count;
    glog.delete();
    push_wr(1, 32'h40, 32'hAAAA_5555);
    tick();
    tick();
    check("rstw_issued", glog_at(0), 32'h40);
    #2;
    bus.M0_HADDR  = 32'h44;
    bus.M0_HTRANS = 2'b10;
    HRESET = 1'b1;
    #1;
    check("rstw_m0_hready", 32'(bus.M0_HREADY), 32'd1);
    check("rstw_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("rstw_s_htrans",  32'(bus.S_HTRANS),  32'd0);
    check("rstw_s_hsel",    32'(bus.S_HSEL),    32'd0);
    @(negedge HCLK);
    check("rstw_next_m0_hready", 32'(bus.M0_HREADY), 32'd1);
    check("rstw_next_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("rstw_next_s_htrans",  32'(bus.S_HTRANS),  32'd0);
    do_reset();
    repeat (3) tick();
    check("rstw_no_ram_write", 32'(wr_count - wr0), 32'd0);
    check("rstw_mem_0x40",     mem[32'h40 >> 2], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_ram_arbiter.md
AHBL_RAM_ARBITER -- requirements
Module: ahbl_ram_arbiter

Interface
REQ-001 SHALL have parameter MAX_GRANT, default 4, max consecutive address-phase grants to one master while the other requests.
REQ-002 SHALL have port HCLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port HRESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports Mx_HADDR/Mx_HTRANS/Mx_HSIZE/Mx_HWRITE  in  32/2/3/1  master x∈{0,1} address phase.
REQ-005 SHALL have port Mx_HWDATA  in  32  master x write data.
REQ-006 SHALL have ports Mx_HREADY/Mx_HRDATA  out  1/32  master x ready and read data.
REQ-007 SHALL have ports S_HADDR/S_HTRANS/S_HSIZE/S_HWRITE/S_HSEL/S_HREADY  out  32/2/3/1/1/1  RAM slave address phase.
REQ-008 SHALL have port S_HWDATA  out  32  RAM write data.
REQ-009 SHALL have ports S_HREADYOUT/S_HRDATA  in  1/32  RAM response.

Function
REQ-010 SHALL treat master x as requesting when pend_x=1, or Mx_HREADY=1 and Mx_HTRANS[1]=1.
REQ-011 SHALL issue at most one address phase per cycle, only in cycles with S_HREADYOUT=1.
REQ-012 SHALL drive S_HREADY=S_HREADYOUT.
REQ-013 SHALL give a buffered request of master x priority over master x's live bus.
REQ-014 SHALL resolve simultaneous requests by arbitration policy (REQ-025), except that after MAX_GRANT consecutive grants to one master the other wins.
REQ-015 SHALL drive S_* address signals from the winner (pend buffer or live bus), S_HSEL=1; with no winner, S_HTRANS=2'b00, S_HSEL=0.
REQ-016 SHALL capture a losing live request (HADDR, HTRANS, HSIZE, HWRITE) into pend_x and set pend_x=1.
REQ-017 SHALL also capture a live request into pend_x when S_HREADYOUT=0.
REQ-018 SHALL clear pend_x in the cycle its buffered request is issued with S_HREADYOUT=1.
REQ-019 SHALL record data-phase owner dp_owner and dp_valid on each issued address phase; dp_valid=0 after a cycle with no issue and S_HREADYOUT=1.
REQ-020 SHALL drive Mx_HREADY=S_HREADYOUT when dp_valid=1 and dp_owner=x; else 0 when pend_x=1 or x's issued buffered transfer is not yet complete; else 1.
REQ-021 SHALL mux S_HWDATA from Mdp_owner_HWDATA; SHALL fan S_HRDATA to both Mx_HRDATA.
REQ-022 SHALL keep the consecutive-grant counter saturating at MAX_GRANT; reset to 1 on owner change; reset to 0 when a cycle issues nothing.
REQ-023 SHALL add zero latency to an uncontended transfer; a buffered transfer adds one wait state per lost arbitration cycle.

Reset
REQ-024 SHALL, while HRESET=1 (asynchronously, including mid-transfer), clear pend_0, pend_1, dp_valid, grant counter; set round-robin pointer to M0; outputs Mx_HREADY=1, S_HTRANS=2'b00, S_HSEL=0; in-flight transfers are dropped.

Configuration
REQ-025 SHALL, with macro AHBL_ARB_ROUND_ROBIN_EN defined, resolve conflicts round-robin (pointer toggles to the other master after each contested grant); without it, M0 always wins conflicts (MAX_GRANT still applies).

Verification
REQ-026 Reset: assert HRESET mid-write from M1 -> next cycle M0_HREADY=M1_HREADY=1, S_HTRANS=00, no RAM write after deassert.
REQ-027 Uncontended: M0 word write 0xDEADBEEF to 0x100, then read 0x100 -> M0_HREADY never low, M0_HRDATA=0xDEADBEEF in read data phase.
REQ-028 Collision: M0 and M1 both NONSEQ word write same cycle (0x10=0x11111111, 0x14=0x22222222), macro off -> M0 issued first, M1_HREADY low exactly one extra cycle, both words in RAM.
REQ-029 Round-robin: macro on, both masters issue 6 back-to-back reads -> S grants alternate M0,M1,M0,...; each master's HRDATA matches its own address.
REQ-030 Starvation cap: macro off, MAX_GRANT=4, M0 streams 10 reads, M1 one read -> M1 issued after 4th M0 grant, M0_HREADY low one cycle then resumes.
REQ-031 Slave wait: force S_HREADYOUT=0 for 3 cycles during M1 data phase while M0 requests -> M0 captured in pend_0, issued first cycle S_HREADYOUT=1, no lost or duplicated transfers.
